// File: rtl/bus_pkg.sv
// Shared types and decode constants for the 68000 bus-cycle controller.
package bus_pkg;

  typedef enum logic [2:0] {
    ROM,
    RAM,
    LED,
    ACIA,
    UNMAPPED
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    PERIPH,
    BERR
  } state_t;

  localparam logic [3:0] REG_ROM  = 4'h0;
  localparam logic [3:0] REG_RAM  = 4'h1;
  localparam logic [3:0] REG_LED  = 4'h2;
  localparam logic [3:0] REG_ACIA = 4'h3;

endpackage

// File: rtl/bus_decode.sv
// Address nibble A15..A12 to region; upper address bits mirror the map.
module bus_decode
  import bus_pkg::*;
(
  input  logic [3:0] nib,
  output region_t    region
);

  always_comb begin
    region = UNMAPPED;
    unique case (1'b1)
      (nib == REG_ROM):  region = ROM;
      (nib == REG_RAM):  region = RAM;
      (nib == REG_LED):  region = LED;
      (nib == REG_ACIA): region = ACIA;
      default:           region = UNMAPPED;
    endcase
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// Bus-cycle sequencer for the fx68k: decode, wait states, DTACK/VPA/BERR,
// chip selects, RAM write strobe and the read-data mux.
module m68k_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ROM_WS       = 1,
  parameter int unsigned RAM_WS       = 1,
  parameter int unsigned BERR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic        vma_n,
  input  logic [23:1] addr,
  input  logic [15:0] rom_dout,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  acia_dout,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr_n,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [1:0]  ram_mask,
  output logic        led_cs,
  output logic        acia_cs,
  output logic [15:0] cpu_din
);

  localparam logic [7:0] ROM_W = 8'(ROM_WS);
  localparam logic [7:0] RAM_W = 8'(RAM_WS);
  localparam logic [7:0] BTO   = 8'(BERR_TIMEOUT);

  state_t     st_q, st_d;
  region_t    reg_q, reg_d, dec;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       unused_addr;

  assign unused_addr = ^{addr[23:16], addr[11:1]};

  bus_decode u_dec (
    .nib    (addr[15:12]),
    .region (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      reg_q   <= ROM;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b1;
      first_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    first_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!as_n) begin
          reg_d = dec;
          rw_d  = rw;
          unique case (dec)
            ROM: begin
              st_d  = WAIT;
              cnt_d = ROM_W;
            end
            RAM: begin
              st_d  = WAIT;
              cnt_d = RAM_W;
            end
            LED, ACIA: st_d = PERIPH;
            default: begin
              st_d  = WAIT;
              cnt_d = BTO;
            end
          endcase
        end
      end
      WAIT: begin
        if (as_n) begin
          st_d  = IDLE;
          cnt_d = 8'd0;
        end else if (cnt_q == 8'd0) begin
          if (reg_q == UNMAPPED) begin
            st_d = BERR;
          end else begin
            st_d    = ACK;
            first_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK, PERIPH, BERR: begin
        if (as_n) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Strobes come from registered state so reset clears them at once.
  always_comb begin
    dtack_n  = (st_q != ACK);
    vpa_n    = (st_q != PERIPH);
    berr_n   = (st_q != BERR);
    rom_cs   = (st_q == WAIT || st_q == ACK) && reg_q == ROM;
    ram_cs   = (st_q == WAIT || st_q == ACK) && reg_q == RAM;
    ram_we   = (st_q == ACK) && first_q && reg_q == RAM && !rw_q;
    ram_mask = ram_we ? {!uds_n, !lds_n} : 2'b00;
    led_cs   = (st_q == PERIPH) && reg_q == LED && !vma_n;
    acia_cs  = (st_q == PERIPH) && reg_q == ACIA && !vma_n;
    cpu_din  = rom_dout;
    unique case (reg_q)
      ACIA:    cpu_din = {acia_dout, 8'h00};
      RAM:     cpu_din = ram_dout;
      default: cpu_din = rom_dout;
    endcase
  end

endmodule
